// File: rtl/chu_debounce_core.sv
// chu_debounce_core: MMIO slot core that synchronises and debounces W raw inputs and records
// sticky rise/fall events for firmware polling.
//
// Ports:
//   clk      system clock, all logic rising-edge
//   reset    asynchronous active-low reset
//   cs       slot select
//   read     read strobe (reads have no side effects; unused)
//   write    write strobe, qualified by cs
//   addr     register index: 0 level, 1 rise W1C, 2 fall W1C, 3 period
//   wr_data  write data
//   rd_data  combinational read data for addr
//   din      raw asynchronous inputs
module chu_debounce_core #(
  parameter int unsigned W          = 8,
  parameter int unsigned CNT_BITS   = 20,
  parameter int unsigned DB_DEFAULT = 500_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  din
);

  localparam logic [CNT_BITS-1:0] CntOne     = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] PeriodRst  = CNT_BITS'(DB_DEFAULT);

  logic [W-1:0]        sync1_q, sync2_q;
  logic [W-1:0]        stable_q, stable_d;
  logic [W-1:0]        rise_q, rise_d;
  logic [W-1:0]        fall_q, fall_d;
  logic [CNT_BITS-1:0] period_q, period_d;
  logic [CNT_BITS-1:0] cnt_q [W];
  logic [CNT_BITS-1:0] cnt_d [W];

  logic                wr_en;
  logic                period_wr;
  logic [CNT_BITS-1:0] peff;
  logic [W-1:0]        rise_clr, fall_clr;

  // Reads are side-effect free, and upper write-data bits may not map to any register.
  logic unused_bits;
  assign unused_bits = ^{read, wr_data};

  always_comb begin
    wr_en     = cs & write;
    period_wr = wr_en && (addr == 5'd3);
    // A programmed period of 0 behaves as 1 so the terminal count is always reachable.
    peff      = (period_q == '0) ? CntOne : period_q;
    stable_d  = stable_q;
    for (int i = 0; i < int'(W); i++) begin
      cnt_d[i] = cnt_q[i];
      if (period_wr) begin
        // Restart every count under the new period; levels are left alone.
        cnt_d[i] = '0;
      end else if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == peff - CntOne) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end

    rise_clr = (wr_en && (addr == 5'd1)) ? wr_data[W-1:0] : '0;
    fall_clr = (wr_en && (addr == 5'd2)) ? wr_data[W-1:0] : '0;
    // New events are ORed in after the clear so a coincident set wins.
    rise_d   = (rise_q & ~rise_clr) | (stable_d & ~stable_q);
    fall_d   = (fall_q & ~fall_clr) | (~stable_d & stable_q);
    period_d = period_wr ? wr_data[CNT_BITS-1:0] : period_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      period_q <= PeriodRst;
      for (int i = 0; i < int'(W); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      period_q <= period_d;
      for (int i = 0; i < int'(W); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0:    rd_data[W-1:0]        = stable_q;
      5'd1:    rd_data[W-1:0]        = rise_q;
      5'd2:    rd_data[W-1:0]        = fall_q;
      5'd3:    rd_data[CNT_BITS-1:0] = period_q;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_debounce_core.sv
// Scoreboard bench for chu_debounce_core: each stimulus cycle that reads pushes its expected
// value; a negedge monitor pops and compares whenever a read is presented.
module tb_chu_debounce_core;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  din;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] m_exp;
  string       m_name;

  chu_debounce_core #(
    .W          (8),
    .CNT_BITS   (20),
    .DB_DEFAULT (500_000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .din     (din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare read data mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cs && read) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read addr=%0d got=%0h (no expected value queued)", addr, rd_data);
      end else begin
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        if (rd_data !== m_exp) begin
          n_fail++;
          $display("FAIL %s t=%0t addr=%0d got=%0h expected=%0h", m_name, $time, addr, rd_data,
                   m_exp);
        end
      end
    end
  end

  // One bus cycle, entered and left at posedge+1. Writes land on the closing edge.
  task automatic cyc(input bit rd, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                     input logic [31:0] exp, input string nm);
    cs      = rd | wr;
    read    = rd;
    write   = wr;
    addr    = a;
    wr_data = wd;
    if (rd) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    cs    = 1'b0;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp, input string nm);
    cyc(1'b1, 1'b0, a, 32'h0, exp, nm);
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] wd);
    cyc(1'b0, 1'b1, a, wd, 32'h0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, "");
  endtask

  initial begin
    reset   = 1'b0;
    cs      = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    wr_data = '0;
    din     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset values and unmapped address.
    rd_reg(5'd0, 32'd0, "rst_level");
    rd_reg(5'd1, 32'd0, "rst_rise");
    rd_reg(5'd2, 32'd0, "rst_fall");
    rd_reg(5'd3, 32'd500_000, "rst_period");
    rd_reg(5'd7, 32'd0, "rst_addr7");

    // P=10: pin edge to stable takes 12 clocks.
    wr_reg(5'd3, 32'd10);
    din = 8'h01;
    for (int k = 1; k <= 13; k++) rd_reg(5'd0, (k >= 13) ? 32'h1 : 32'h0, "lat12_level");
    rd_reg(5'd1, 32'h1, "lat12_rise");
    rd_reg(5'd2, 32'h0, "lat12_fall");

    // 9-clock glitch on bit 1 is rejected.
    din = 8'h03;
    for (int k = 1; k <= 9; k++) rd_reg(5'd0, 32'h1, "glitch9_during");
    din = 8'h01;
    for (int k = 1; k <= 14; k++) rd_reg(5'd0, 32'h1, "glitch9_after");
    rd_reg(5'd1, 32'h1, "glitch9_rise");

    // 10-clock pulse on bit 1 is accepted, then released.
    din = 8'h03;
    for (int k = 1; k <= 10; k++) rd_reg(5'd0, 32'h1, "pulse10_high");
    din = 8'h01;
    for (int k = 11; k <= 23; k++) begin
      rd_reg(5'd0, (k == 13 || (k >= 14 && k <= 22)) ? 32'h3 : 32'h1, "pulse10_level");
    end
    rd_reg(5'd1, 32'h3, "pulse10_rise");
    rd_reg(5'd2, 32'h2, "pulse10_fall");

    // Write-1-to-clear behaviour.
    wr_reg(5'd1, 32'h1);
    rd_reg(5'd1, 32'h2, "w1c_bit0");
    wr_reg(5'd1, 32'hFFFF_FF00);
    rd_reg(5'd1, 32'h2, "w1c_high_bits_ignored");
    wr_reg(5'd1, 32'h2);
    rd_reg(5'd1, 32'h0, "w1c_bit1");
    wr_reg(5'd2, 32'hFF);
    rd_reg(5'd2, 32'h0, "w1c_fall_all");

    // Falling edge of bit 0 sets fall flag.
    din = 8'h00;
    for (int k = 1; k <= 13; k++) rd_reg(5'd0, (k < 13) ? 32'h1 : 32'h0, "fall0_level");
    rd_reg(5'd2, 32'h1, "fall0_flag");
    rd_reg(5'd1, 32'h0, "fall0_no_rise");

    // W1C on the same edge the rise sets: flag survives.
    din = 8'h01;
    for (int k = 1; k <= 11; k++) rd_reg(5'd0, 32'h0, "collide_pre");
    wr_reg(5'd1, 32'h1);
    rd_reg(5'd1, 32'h1, "collide_set_wins");
    rd_reg(5'd0, 32'h1, "collide_level");

    // P=0 behaves as P=1: 3-clock latency.
    wr_reg(5'd3, 32'd0);
    rd_reg(5'd3, 32'd0, "p0_readback");
    din = 8'h00;
    for (int k = 1; k <= 4; k++) rd_reg(5'd0, (k < 4) ? 32'h1 : 32'h0, "p0_level");

    // Period change mid-count restarts the count under the new period.
    wr_reg(5'd3, 32'd200);
    din = 8'h01;
    idle(52);
    wr_reg(5'd3, 32'd100);
    idle(99);
    rd_reg(5'd0, 32'h0, "pchg_before");
    rd_reg(5'd0, 32'h1, "pchg_after");
    rd_reg(5'd3, 32'd100, "pchg_period");

    // Async reset mid-count with flags set.
    rd_reg(5'd1, 32'h1, "prerst_rise");
    rd_reg(5'd2, 32'h1, "prerst_fall");
    din = 8'h00;
    idle(30);
    reset = 1'b0;
    rd_reg(5'd0, 32'h0, "async_rst_level");
    rd_reg(5'd1, 32'h0, "async_rst_rise");
    rd_reg(5'd2, 32'h0, "async_rst_fall");
    rd_reg(5'd3, 32'd500_000, "async_rst_period");
    reset = 1'b1;
    rd_reg(5'd3, 32'd500_000, "post_rst_period");
    idle(2);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
